// File: rtl/lut_banked_dm_if.sv
// lut_banked_dm_if
//   Bundles the lookup, table-write, status and statistics signals of
//   lut_banked_dm.
//   master : drives LookupReq/EntryReg/MuxReg and WrEn/WrBank/WrEntry/WrData,
//            observes Target/LookupValid/Miss/Busy/LookupCount/MissCount.
//   slave  : the LUT itself (opposite directions).
interface lut_banked_dm_if #(
  parameter int W = 8
);
  logic         LookupReq;
  logic [W-1:0] EntryReg;
  logic [W-1:0] MuxReg;
  logic [W-1:0] Target;
  logic         LookupValid;
  logic         Miss;
  logic         WrEn;
  logic [W-1:0] WrBank;
  logic [W-1:0] WrEntry;
  logic [W-1:0] WrData;
  logic         Busy;
  logic [15:0]  LookupCount;
  logic [15:0]  MissCount;

  modport master (
    output LookupReq, EntryReg, MuxReg, WrEn, WrBank, WrEntry, WrData,
    input  Target, LookupValid, Miss, Busy, LookupCount, MissCount
  );

  modport slave (
    input  LookupReq, EntryReg, MuxReg, WrEn, WrBank, WrEntry, WrData,
    output Target, LookupValid, Miss, Busy, LookupCount, MissCount
  );
endinterface

// File: rtl/lut_banked_dm.sv
// lut_banked_dm
//   Runtime-loadable banked LUT mapping (MuxReg = bank, EntryReg = entry) to a
//   DataMem address. After reset the table fills itself with the default image
//   (one entry per cycle, Busy high), then serves registered lookups with a
//   one-cycle LookupValid pulse and accepts single-entry rewrites.
//   Ports:
//     Clk    : clock
//     Reset  : asynchronous, active-low reset
//     bus    : lut_banked_dm_if.slave (lookup request/response, table write,
//              Busy, optional statistics counters)
//   Optional feature macro: LUT_BANKED_STATS_EN enables the saturating
//   LookupCount/MissCount counters; otherwise both read as constant 0.
module lut_banked_dm #(
  parameter int           W        = 8,
  parameter int           BANKS    = 2,
  parameter int           ENTRIES  = 16,
  parameter logic [W-1:0] MISS_VAL = W'(8'hFF)
) (
  input logic             Clk,
  input logic             Reset,
  lut_banked_dm_if.slave  bus
);
  localparam int DEPTH = BANKS * ENTRIES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t        stateReg, stateNext;
  logic [AW-1:0] initAddrReg, initAddrNext;
  logic [AW-1:0] initBankReg, initBankNext;
  logic [AW-1:0] initEntryReg, initEntryNext;
  logic          initWe;

  logic [W-1:0]  mem [DEPTH];
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [W-1:0]  memData;

  logic          lkAccept, lkMiss;
  logic [AW-1:0] lkAddr;
  logic          wrAccept;
  logic [AW-1:0] wrAddr;

  logic [W-1:0]  targetReg;
  logic          lookupValidReg, missReg;

  // Default image. Bank 1 holds s minus the number of powers of two <= s,
  // except entry 0 and exact powers of two which hold 0x0C.
  function automatic logic [W-1:0] defaultVal(input int bank, input int entry);
    int           pow2Count;
    logic [W-1:0] val;
    pow2Count = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) <= entry) pow2Count++;
    end
    if (bank == 0) begin
      val = (entry == 0) ? '0 : W'(8'h0D);
    end else if (bank == 1) begin
      val = (entry == 0 || (entry & (entry - 1)) == 0) ? W'(8'h0C) : W'(entry - pow2Count);
    end else begin
      val = MISS_VAL;
    end
    return val;
  endfunction

  // Full-width range checks: upper index bits must not alias into the table.
  always_comb begin
    lkMiss   = !(32'(bus.MuxReg) < BANKS && 32'(bus.EntryReg) < ENTRIES);
    lkAddr   = AW'(32'(bus.MuxReg) * ENTRIES + 32'(bus.EntryReg));
    lkAccept = bus.LookupReq && (stateReg == RUN);
    wrAddr   = AW'(32'(bus.WrBank) * ENTRIES + 32'(bus.WrEntry));
    wrAccept = bus.WrEn && (stateReg == RUN) &&
               32'(bus.WrBank) < BANKS && 32'(bus.WrEntry) < ENTRIES;
  end

  // Init sweep FSM: state and pointers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateReg     <= INIT;
      initAddrReg  <= '0;
      initBankReg  <= '0;
      initEntryReg <= '0;
    end else begin
      stateReg     <= stateNext;
      initAddrReg  <= initAddrNext;
      initBankReg  <= initBankNext;
      initEntryReg <= initEntryNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    initAddrNext  = initAddrReg;
    initBankNext  = initBankReg;
    initEntryNext = initEntryReg;
    initWe        = 1'b0;
    case (stateReg)
      INIT: begin
        initWe = 1'b1;
        if (initAddrReg == AW'(DEPTH - 1)) begin
          stateNext     = RUN;
          initAddrNext  = '0;
          initBankNext  = '0;
          initEntryNext = '0;
        end else begin
          initAddrNext = initAddrReg + AW'(1);
          if (initEntryReg == AW'(ENTRIES - 1)) begin
            initEntryNext = '0;
            initBankNext  = initBankReg + AW'(1);
          end else begin
            initEntryNext = initEntryReg + AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Single write port shared by the init sweep and runtime reprogramming;
  // the two never overlap because runtime writes need RUN.
  always_comb begin
    memWe   = initWe | wrAccept;
    memAddr = initWe ? initAddrReg : wrAddr;
    memData = initWe ? defaultVal(32'(initBankReg), 32'(initEntryReg)) : bus.WrData;
  end

  always_ff @(posedge Clk) begin
    if (memWe) mem[memAddr] <= memData;
  end

  // Registered read: a write to the same entry on the same edge lands after
  // the read, so the lookup sees the old contents.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      targetReg      <= '0;
      lookupValidReg <= 1'b0;
      missReg        <= 1'b0;
    end else begin
      lookupValidReg <= lkAccept;
      if (lkAccept) begin
        missReg   <= lkMiss;
        targetReg <= lkMiss ? MISS_VAL : mem[lkAddr];
      end
    end
  end

  assign bus.Target      = targetReg;
  assign bus.LookupValid = lookupValidReg;
  assign bus.Miss        = missReg;
  assign bus.Busy        = (stateReg == INIT);

`ifdef LUT_BANKED_STATS_EN
  logic [15:0] lookupCountReg, missCountReg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lookupCountReg <= '0;
      missCountReg   <= '0;
    end else if (lkAccept) begin
      if (lookupCountReg != 16'hFFFF) lookupCountReg <= lookupCountReg + 16'd1;
      if (lkMiss && missCountReg != 16'hFFFF) missCountReg <= missCountReg + 16'd1;
    end
  end

  assign bus.LookupCount = lookupCountReg;
  assign bus.MissCount   = missCountReg;
`else
  assign bus.LookupCount = '0;
  assign bus.MissCount   = '0;
`endif
endmodule

// File: tb/tb_lut_banked_dm.sv
// tb_lut_banked_dm
//   Directed plus randomized checks of lut_banked_dm against a table model
//   built from the mapping rules (default image, range check, read-before-write).
module tb_lut_banked_dm;
  logic Clk;
  logic Reset;

  lut_banked_dm_if #(.W(8)) bus ();

  lut_banked_dm #(
    .W(8), .BANKS(2), .ENTRIES(16), .MISS_VAL(8'hFF)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam logic [7:0] BANK1_DEF [16] = '{
    8'h0C, 8'h0C, 8'h0C, 8'h01, 8'h0C, 8'h02, 8'h03, 8'h04,
    8'h0C, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B
  };

  logic [7:0] model [2][16];
  int         modelLookups;
  int         modelMisses;
  logic [7:0] expTarget;
  int         checkCount;
  int         passCount;
  int         failCount;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    for (int b = 0; b < 2; b++)
      for (int e = 0; e < 16; e++)
        model[b][e] = (b == 0) ? ((e == 0) ? 8'h00 : 8'h0D) : BANK1_DEF[e];
    modelLookups = 0;
    modelMisses  = 0;
    expTarget    = 8'h00;
  endfunction

  function automatic void modelRead(input logic [7:0] bank, input logic [7:0] entry,
                                    output logic [7:0] t, output logic m);
    m = (bank >= 8'd2) || (entry >= 8'd16);
    t = m ? 8'hFF : model[bank[0]][entry[3:0]];
  endfunction

  function automatic void modelWrite(input logic [7:0] bank, input logic [7:0] entry,
                                     input logic [7:0] data);
    if (bank < 8'd2 && entry < 8'd16) model[bank[0]][entry[3:0]] = data;
  endfunction

  function automatic void modelCount(input logic m);
    if (modelLookups < 65535) modelLookups++;
    if (m && modelMisses < 65535) modelMisses++;
  endfunction

  task automatic checkStats(input string tag);
`ifdef LUT_BANKED_STATS_EN
    check({tag, " LookupCount"}, 32'(bus.LookupCount), 32'(modelLookups));
    check({tag, " MissCount"}, 32'(bus.MissCount), 32'(modelMisses));
`else
    check({tag, " LookupCount"}, 32'(bus.LookupCount), 32'd0);
    check({tag, " MissCount"}, 32'(bus.MissCount), 32'd0);
`endif
  endtask

  // Called at a negedge; issues one lookup and checks the response one edge later.
  task automatic doLookup(input string tag, input logic [7:0] bank, input logic [7:0] entry);
    logic [7:0] t;
    logic       m;
    modelRead(bank, entry, t, m);
    modelCount(m);
    bus.LookupReq = 1'b1;
    bus.MuxReg    = bank;
    bus.EntryReg  = entry;
    @(negedge Clk);
    bus.LookupReq = 1'b0;
    check({tag, " valid"}, 32'(bus.LookupValid), 32'd1);
    check({tag, " target"}, 32'(bus.Target), 32'(t));
    check({tag, " miss"}, 32'(bus.Miss), 32'(m));
    expTarget = t;
  endtask

  // Counts cycles with Busy high (bounded) and reports any LookupValid seen.
  task automatic waitInit(input string tag);
    int   busyCycles;
    logic sawValid;
    busyCycles = 0;
    sawValid   = 1'b0;
    while (bus.Busy === 1'b1 && busyCycles < 100) begin
      busyCycles++;
      @(negedge Clk);
      if (bus.LookupValid !== 1'b0) sawValid = 1'b1;
    end
    check({tag, " busy cycles"}, 32'(busyCycles), 32'd32);
    check({tag, " no valid during init"}, 32'(sawValid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         bbEntry [3];
    logic       rReq, rWr, m;
    logic [7:0] rBank, rEntry, wBank, wEntry, wData, t;

    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    modelReset();
    Reset         = 1'b0;
    bus.LookupReq = 1'b0;
    bus.EntryReg  = '0;
    bus.MuxReg    = '0;
    bus.WrEn      = 1'b0;
    bus.WrBank    = '0;
    bus.WrEntry   = '0;
    bus.WrData    = '0;
    repeat (3) @(negedge Clk);

    check("reset Target", 32'(bus.Target), 32'h00);
    check("reset LookupValid", 32'(bus.LookupValid), 32'd0);
    check("reset Miss", 32'(bus.Miss), 32'd0);
    check("reset Busy", 32'(bus.Busy), 32'd1);
    checkStats("reset");

    // Lookup and write requests held through init must both be ignored.
    bus.LookupReq = 1'b1; bus.MuxReg = 8'd1; bus.EntryReg = 8'd7;
    bus.WrEn = 1'b1; bus.WrBank = 8'd0; bus.WrEntry = 8'd5; bus.WrData = 8'h77;
    Reset = 1'b1;
    waitInit("init");
    bus.LookupReq = 1'b0;
    bus.WrEn      = 1'b0;
    check("post-init Busy", 32'(bus.Busy), 32'd0);
    checkStats("post-init");

    doLookup("lk(1,7)", 8'd1, 8'd7);
    doLookup("lk(0,0)", 8'd0, 8'd0);
    doLookup("lk(0,5)", 8'd0, 8'd5);

    doLookup("miss(2,3)", 8'd2, 8'd3);
    doLookup("miss(0,16)", 8'd0, 8'd16);
    doLookup("miss(0x81,0)", 8'h81, 8'd0);
    doLookup("miss(1,0x83)", 8'd1, 8'h83);
    checkStats("after misses");

    // Same-edge write and lookup of (1,3): old value first, new value next.
    bus.WrEn = 1'b1; bus.WrBank = 8'd1; bus.WrEntry = 8'd3; bus.WrData = 8'h2A;
    doLookup("rbw old(1,3)", 8'd1, 8'd3);
    bus.WrEn = 1'b0;
    modelWrite(8'd1, 8'd3, 8'h2A);
    doLookup("rbw new(1,3)", 8'd1, 8'd3);

    // Out-of-range writes that would alias onto (0,3)/(1,3) if truncated.
    bus.WrEn = 1'b1; bus.WrBank = 8'd2; bus.WrEntry = 8'd3; bus.WrData = 8'h55;
    @(negedge Clk);
    bus.WrBank = 8'd1; bus.WrEntry = 8'h13; bus.WrData = 8'h66;
    @(negedge Clk);
    bus.WrEn = 1'b0;
    doLookup("oor wr(0,3)", 8'd0, 8'd3);
    doLookup("oor wr(1,3)", 8'd1, 8'd3);

    // Back-to-back lookups on consecutive cycles.
    bbEntry = '{9, 12, 15};
    for (int i = 0; i < 3; i++) begin
      modelRead(8'd1, 8'(bbEntry[i]), t, m);
      modelCount(m);
      bus.LookupReq = 1'b1; bus.MuxReg = 8'd1; bus.EntryReg = 8'(bbEntry[i]);
      @(negedge Clk);
      check($sformatf("b2b(1,%0d) valid", bbEntry[i]), 32'(bus.LookupValid), 32'd1);
      check($sformatf("b2b(1,%0d) target", bbEntry[i]), 32'(bus.Target), 32'(t));
      expTarget = t;
    end
    bus.LookupReq = 1'b0;
    @(negedge Clk);
    check("b2b idle valid", 32'(bus.LookupValid), 32'd0);
    check("b2b idle target hold", 32'(bus.Target), 32'(expTarget));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rReq   = 1'($urandom_range(0, 1));
      rBank  = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255));
      rEntry = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 17)) : 8'($urandom_range(0, 255));
      rWr    = ($urandom_range(0, 2) == 0);
      wBank  = 8'($urandom_range(0, 2));
      wEntry = 8'($urandom_range(0, 17));
      wData  = 8'($urandom_range(0, 255));
      t = 8'h00;
      m = 1'b0;
      if (rReq) begin
        modelRead(rBank, rEntry, t, m);
        modelCount(m);
      end
      bus.LookupReq = rReq; bus.MuxReg = rBank; bus.EntryReg = rEntry;
      bus.WrEn = rWr; bus.WrBank = wBank; bus.WrEntry = wEntry; bus.WrData = wData;
      @(negedge Clk);
      if (rWr) modelWrite(wBank, wEntry, wData);
      check($sformatf("rnd%0d valid", i), 32'(bus.LookupValid), 32'(rReq));
      if (rReq) begin
        expTarget = t;
        check($sformatf("rnd%0d miss(%0h,%0h)", i, rBank, rEntry), 32'(bus.Miss), 32'(m));
      end
      check($sformatf("rnd%0d target(%0h,%0h)", i, rBank, rEntry), 32'(bus.Target), 32'(expTarget));
    end
    bus.LookupReq = 1'b0;
    bus.WrEn      = 1'b0;
    @(negedge Clk);
    checkStats("after random");

    // Reset mid-RUN with a response in flight: everything clears at once.
    bus.LookupReq = 1'b1; bus.MuxReg = 8'd1; bus.EntryReg = 8'd3;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    check("midrun reset LookupValid", 32'(bus.LookupValid), 32'd0);
    check("midrun reset Target", 32'(bus.Target), 32'h00);
    check("midrun reset Busy", 32'(bus.Busy), 32'd1);
    @(negedge Clk);
    bus.LookupReq = 1'b0;
    modelReset();
    checkStats("midrun reset");
    Reset = 1'b1;
    waitInit("reinit");
    doLookup("reinit lk(1,3)", 8'd1, 8'd3);
    doLookup("reinit lk(1,7)", 8'd1, 8'd7);

    // Reset mid-INIT restarts the full sweep.
    bus.WrEn = 1'b1; bus.WrBank = 8'd1; bus.WrEntry = 8'd3; bus.WrData = 8'h3C;
    @(negedge Clk);
    bus.WrEn = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    modelReset();
    Reset = 1'b1;
    repeat (10) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    waitInit("midinit restart");
    doLookup("midinit lk(1,3)", 8'd1, 8'd3);
    doLookup("midinit lk(0,15)", 8'd0, 8'd15);
    checkStats("final");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
